// File: rtl/lc3b_microsequencer.sv
// ----------------------------------------------------------------------------
// lc3b_microsequencer
//
// Purpose:
//   Control-unit state sequencer for the LC-3b. It walks the fetch loop
//   (18 -> 19 -> 33 -> 35 -> 32), dispatches on IR[15:12] in state 32 and then
//   runs the per-opcode execute path before returning to 18. Memory wait states
//   can time out into a terminal error state (63). Unsupported opcodes are
//   funnelled through illegal state 10 or 11. An interrupt check at state 18
//   can be enabled.
//
// Parameters:
//   STATE_W     width of stateID (>= 6)
//   MEM_TIMEOUT cycles allowed with R=0 in a memory state; 0 = wait forever
//   INT_EN      1 = state 18 may branch to 49 on int_req
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (state -> 18)
//   R          in   memory ready
//   ir_op      in   IR[15:12], valid from state 32 onward
//   ir11       in   IR[11], JSR (1) vs JSRR (0)
//   ben        in   branch enable, valid in state 0
//   int_req    in   level interrupt request, sampled only in state 18
//   stateID    out  current microstate (the FSM state register itself)
//   int_ack    out  high while in state 49
//   illegal_op out  high while in state 10 or 11
//   mem_err    out  high while in state 63 (terminal until reset)
//
// Every output is decoded from the state register alone, so all of them are
// glitch-free with respect to the inputs and change only on a clock edge or
// on reset.
// ----------------------------------------------------------------------------
module lc3b_microsequencer #(
    parameter int STATE_W     = 6,
    parameter int MEM_TIMEOUT = 0,
    parameter int INT_EN      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               R,
    input  logic [3:0]         ir_op,
    input  logic               ir11,
    input  logic               ben,
    input  logic               int_req,
    output logic [STATE_W-1:0] stateID,
    output logic               int_ack,
    output logic               illegal_op,
    output logic               mem_err
);

    // Microstate encodings
    localparam logic [STATE_W-1:0] S_BR      = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_ADD     = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_JSR     = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_AND     = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_LDW     = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_STW     = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_XOR     = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ILL_A   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_ILL_B   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_JMP     = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_SHF     = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_LEA     = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_TRAP    = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_STW_MEM = STATE_W'(16);
    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(18);
    localparam logic [STATE_W-1:0] S_MAR_PC  = STATE_W'(19);
    localparam logic [STATE_W-1:0] S_JSRR    = STATE_W'(20);
    localparam logic [STATE_W-1:0] S_JSR_PC  = STATE_W'(21);
    localparam logic [STATE_W-1:0] S_BR_TAKE = STATE_W'(22);
    localparam logic [STATE_W-1:0] S_STW_MDR = STATE_W'(23);
    localparam logic [STATE_W-1:0] S_LDW_MEM = STATE_W'(25);
    localparam logic [STATE_W-1:0] S_LDW_DR  = STATE_W'(27);
    localparam logic [STATE_W-1:0] S_TRAP_MEM= STATE_W'(28);
    localparam logic [STATE_W-1:0] S_TRAP_PC = STATE_W'(30);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(32);
    localparam logic [STATE_W-1:0] S_IFETCH  = STATE_W'(33);
    localparam logic [STATE_W-1:0] S_IR_LOAD = STATE_W'(35);
    localparam logic [STATE_W-1:0] S_INT     = STATE_W'(49);
    localparam logic [STATE_W-1:0] S_MEM_ERR = STATE_W'(63);

    // Wait counter sized to hold MEM_TIMEOUT; one bit when timeouts are off.
    localparam int CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int LIMIT_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_I);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_is_wait;
    logic               w_timeout;

    assign w_is_wait = (r_state == S_IFETCH) || (r_state == S_LDW_MEM) ||
                       (r_state == S_STW_MEM) || (r_state == S_TRAP_MEM);

    // Timeout fires on the cycle the counter sits at the limit with R still
    // low; R=1 on that same cycle wins because each wait state tests R first.
    assign w_timeout = (MEM_TIMEOUT > 0) && (r_cnt == LIMIT) && !R;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: counts R=0 cycles while remaining in one wait state and
    // clears whenever the state is left or entered. Staying implies the limit
    // was not yet reached, so the increment can never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((MEM_TIMEOUT > 0) && w_is_wait && (w_next == r_state)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = ((INT_EN != 0) && int_req) ? S_INT : S_MAR_PC;
            S_INT:      w_next = S_FETCH;
            S_MAR_PC:   w_next = S_IFETCH;
            S_IFETCH:   w_next = R ? S_IR_LOAD : (w_timeout ? S_MEM_ERR : S_IFETCH);
            S_IR_LOAD:  w_next = S_DECODE;
            S_DECODE: begin
                case (ir_op)
                    4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9,
                    4'd12, 4'd13, 4'd14, 4'd15: w_next = STATE_W'(ir_op);
                    4'd11:                      w_next = S_ILL_B;
                    // RTI and the byte loads/stores share the illegal path.
                    default:                    w_next = S_ILL_A;
                endcase
            end
            S_BR:       w_next = ben ? S_BR_TAKE : S_FETCH;
            S_JSR:      w_next = ir11 ? S_JSR_PC : S_JSRR;
            S_LDW:      w_next = S_LDW_MEM;
            S_LDW_MEM:  w_next = R ? S_LDW_DR : (w_timeout ? S_MEM_ERR : S_LDW_MEM);
            S_STW:      w_next = S_STW_MDR;
            S_STW_MDR:  w_next = S_STW_MEM;
            S_STW_MEM:  w_next = R ? S_FETCH : (w_timeout ? S_MEM_ERR : S_STW_MEM);
            S_TRAP:     w_next = S_TRAP_MEM;
            S_TRAP_MEM: w_next = R ? S_TRAP_PC : (w_timeout ? S_MEM_ERR : S_TRAP_MEM);
            S_MEM_ERR:  w_next = S_MEM_ERR;
            S_ADD, S_AND, S_XOR, S_JMP, S_SHF, S_LEA, S_ILL_A, S_ILL_B,
            S_BR_TAKE, S_JSR_PC, S_JSRR, S_LDW_DR, S_TRAP_PC:
                        w_next = S_FETCH;
            // Unencoded values (including any nonzero upper bits) recover to fetch.
            default:    w_next = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        stateID    = r_state;
        int_ack    = (r_state == S_INT);
        illegal_op = (r_state == S_ILL_A) || (r_state == S_ILL_B);
        mem_err    = (r_state == S_MEM_ERR);
    end

endmodule

// File: doc/lc3b_microsequencer.md
Name: lc3b_microsequencer

Overview:
- Parametrised LC-3b control-unit state sequencer. Generalises the fetch-only loop (18→19→33→35→32) into full decode dispatch and per-opcode execute paths.
- Adds a memory-ready timeout, an optional interrupt check at fetch, and illegal-opcode flagging.
- Drives stateID to the control store / datapath decode; consumes memory ready R, IR[15:11] and BEN.

Parameters:
STATE_W, 6, width of stateID; must be ≥6.
MEM_TIMEOUT, 0, max cycles waiting on R in a memory state before error; 0 = wait forever.
INT_EN, 0, 1 enables interrupt check in state 18.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
R  input  1  memory ready, sampled each cycle in memory states
ir_op  input  4  IR[15:12], valid from state 32 onward
ir11  input  1  IR[11] (JSR vs JSRR select)
ben  input  1  branch-enable, valid in state 0
int_req  input  1  level interrupt request
stateID  output  STATE_W  current microstate
int_ack  output  1  one-cycle pulse while in state 49
illegal_op  output  1  one-cycle pulse while in state 10 or 11
mem_err  output  1  sticky; high while in state 63

Behaviour:
- Async reset (reset=0): stateID=18, wait counter=0, all flag outputs 0. On release, first clock edge evaluates transitions from 18.
- All outputs are registered or decoded from stateID only. Next state is one cycle after the current state.
- Fetch path:
  - 18→19; if INT_EN=1 and int_req=1, 18→49 instead.
  - 49→18.
  - 19→33.
  - 33: R=1→35, else stay.
  - 35→32.
- Decode, 32→state numbered ir_op: 0 BR, 1 ADD, 2 LDB, 3 STB, 4 JSR, 5 AND, 6 LDW, 7 STW, 9 XOR/NOT, 10/11 illegal, 12 JMP, 13 SHF, 14 LEA, 15 TRAP.
- 8 (RTI) and 2/3 (byte ops, out of scope) go to 18 via illegal path: 32→10 with illegal_op pulse.
- Execute paths:
  - 1, 5, 9, 12, 13, 14 → 18.
  - 0: ben=1→22→18; ben=0→18.
  - 4: ir11=1→21→18; ir11=0→20→18.
  - 6→25; 25: R=1→27, else stay; 27→18.
  - 7→23→16; 16: R=1→18, else stay.
  - 15→28; 28: R=1→30, else stay; 30→18.
  - 10, 11 → 18.
- Memory wait states are {33, 25, 16, 28}:
  - Counter clears on entry and increments each cycle R=0.
  - If MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT-1 with R=0, next state 63.
  - R=1 on the same cycle as the limit has priority (normal exit).
  - MEM_TIMEOUT=1 means error on the first cycle R=0.
  - Counter width = clog2(MEM_TIMEOUT+1); it never wraps.
- 63: terminal; stays until reset; mem_err=1.
- Any stateID outside the encoded set (including upper bits when STATE_W>6) → 18 next cycle, no flags.
- Interrupt is only sampled in 18; int_req during other states is ignored until the next 18.
- Reset assertion mid-wait or mid-execute immediately forces 18 and clears mem_err/counter; no partial completion.
- Upper stateID bits beyond 6 are always 0 in legal states.

Test Plan:
- Reset low 3 cycles, release, R=1 always, ir_op=1 → stateID sequence 18,19,33,35,32,1,18.
- ir_op=6, R held 0 for 4 cycles in 25 then 1, MEM_TIMEOUT=0 → 25 held exactly 5 cycles, then 27, 18; mem_err stays 0.
- MEM_TIMEOUT=3, R=0 forever from 33 → 33 for 3 cycles then 63, mem_err=1 and held; reset low → stateID=18 asynchronously, mem_err=0.
- ir_op=0 with ben=1 → 0,22,18; repeat with ben=0 → 0,18; ir_op=4, ir11=1 → 4,21,18.
- ir_op=10 → 32,10,18 with illegal_op=1 for exactly one cycle; ir_op=8 → 32,10,18.
- INT_EN=1, int_req=1 at 18 → 49 (int_ack=1 one cycle), 18; with INT_EN=0, same stimulus → 19.
